// File: rtl/cskipa_add_arbiter.sv
// ---------------------------------------------------------------------------
// cskipa_add_arbiter
//
// Purpose:
//   Round-robin arbiter in front of a single shared WIDTH-bit carry-skip
//   adder. Each granted requester supplies two 2*WIDTH-bit operands. The
//   one adder produces the full 2*WIDTH-bit sum over two passes: low halves
//   first, then high halves with the low-half carry chained in. A result
//   appears three cycles after its grant. A new grant can be issued in the
//   same cycle as a result, so back-to-back operations complete every three
//   cycles.
//
// Ports:
//   i_clk        single clock, rising-edge active
//   i_rst        asynchronous active-high reset
//   i_req        per-requester level request, held until granted
//   i_add_term1  packed first operands, requester k at [(k+1)*2W-1 : k*2W]
//   i_add_term2  packed second operands, same packing
//   o_gnt        one-hot grant pulse; operands are captured on that edge
//   o_busy       high while the adder is working on the low or high half
//   o_valid      one-cycle pulse marking o_sum/o_cout/o_id as fresh
//   o_sum        registered 2*WIDTH-bit sum (modulo 2^(2*WIDTH))
//   o_cout       carry out of the top bit of the full sum
//   o_id         index of the requester that owns the current result
// ---------------------------------------------------------------------------
module cskipa_add_arbiter #(
    parameter int WIDTH = 31,
    parameter int NREQ  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NREQ-1:0]            i_req,
    input  logic [NREQ*2*WIDTH-1:0]    i_add_term1,
    input  logic [NREQ*2*WIDTH-1:0]    i_add_term2,
    output logic [NREQ-1:0]            o_gnt,
    output logic                       o_busy,
    output logic                       o_valid,
    output logic [2*WIDTH-1:0]         o_sum,
    output logic                       o_cout,
    output logic [$clog2(NREQ)-1:0]    o_id
);

    localparam int DW   = 2 * WIDTH;
    localparam int IDW  = $clog2(NREQ);
    localparam int SKIP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } StateType;

    StateType           r_state;
    StateType           w_nextState;

    logic [IDW-1:0]     r_ptr;
    logic [NREQ-1:0]    w_arbGnt;
    logic [IDW-1:0]     w_arbId;
    logic               w_arbAny;

    logic [NREQ-1:0]    w_gnt;
    logic               w_busy;
    logic               w_valid;

    logic [DW-1:0]      w_selA;
    logic [DW-1:0]      w_selB;
    logic [DW-1:0]      r_opA;
    logic [DW-1:0]      r_opB;
    logic [IDW-1:0]     r_id;

    logic [WIDTH-1:0]   r_loSum;
    logic               r_loCarry;
    logic [DW-1:0]      r_sum;
    logic               r_cout;
    logic [IDW-1:0]     r_outId;

    logic [WIDTH-1:0]   w_addA;
    logic [WIDTH-1:0]   w_addB;
    logic               w_addCin;
    logic [WIDTH-1:0]   w_addSum;
    logic               w_addCout;

    // Round-robin search. The scan starts at r_ptr, which always points one
    // past the most recent winner, so the previous winner is examined last
    // even when its request is still high.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idxBits;
        w_arbGnt = '0;
        w_arbId  = '0;
        w_arbAny = 1'b0;
        idx      = 0;
        idxBits  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx     = (int'(r_ptr) + i) % NREQ;
            idxBits = IDW'(idx);
            if (!w_arbAny && i_req[idxBits]) begin
                w_arbAny          = 1'b1;
                w_arbGnt[idxBits] = 1'b1;
                w_arbId           = idxBits;
            end
        end
    end

    // State register. Reset drops straight back to IDLE, which abandons any
    // operation in flight before it can raise o_valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-state strobes. Grants are only offered in IDLE and
    // DONE. Offering one in DONE lets the next operation's low half start in
    // the cycle right after the current result is presented.
    always_comb begin
        w_nextState = r_state;
        w_gnt       = '0;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arbAny) begin
                    w_gnt       = w_arbGnt;
                    w_nextState = LO;
                end
            end
            LO: begin
                w_busy      = 1'b1;
                w_nextState = HI;
            end
            HI: begin
                w_busy      = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                w_valid = 1'b1;
                if (w_arbAny) begin
                    w_gnt       = w_arbGnt;
                    w_nextState = LO;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operand mux for the granted requester. The grant is one-hot, so at
    // most one slice is picked up.
    always_comb begin
        w_selA = '0;
        w_selB = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                w_selA = i_add_term1[k*DW +: DW];
                w_selB = i_add_term2[k*DW +: DW];
            end
        end
    end

    // Feed the shared adder. In HI it sees the upper halves and the carry
    // saved from the LO pass. Every other state shows it the lower halves
    // with carry-in 0; that result is only stored while in LO.
    always_comb begin
        w_addA   = r_opA[WIDTH-1:0];
        w_addB   = r_opB[WIDTH-1:0];
        w_addCin = 1'b0;
        if (r_state == HI) begin
            w_addA   = r_opA[DW-1:WIDTH];
            w_addB   = r_opB[DW-1:WIDTH];
            w_addCin = r_loCarry;
        end
    end

    // The single carry-skip adder. Each SKIP-bit group ripples internally.
    // If every bit of a group propagates, the group's carry-out is taken
    // directly from its carry-in instead of from the end of the ripple. This
    // bypass is the short path a long propagate run uses. The last group may
    // be narrower when WIDTH is not a multiple of SKIP.
    always_comb begin
        logic carry;
        logic blkCin;
        logic allProp;
        logic prop;
        carry    = w_addCin;
        blkCin   = w_addCin;
        allProp  = 1'b1;
        prop     = 1'b0;
        w_addSum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i % SKIP) == 0) begin
                blkCin  = carry;
                allProp = 1'b1;
            end
            prop        = w_addA[i] ^ w_addB[i];
            w_addSum[i] = prop ^ carry;
            carry       = (w_addA[i] & w_addB[i]) | (prop & carry);
            allProp     = allProp & prop;
            if (((i % SKIP) == (SKIP - 1)) || (i == WIDTH - 1)) begin
                carry = allProp ? blkCin : carry;
            end
        end
        w_addCout = carry;
    end

    // Datapath registers. Operands and the owner id are latched on the grant
    // edge, so later changes on the inputs cannot affect the operation. The
    // result registers change only when the high half finishes. The
    // published sum, carry and id therefore stay stable from one o_valid to
    // the next, even while a following operation is running.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_id      <= '0;
            r_loSum   <= '0;
            r_loCarry <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_outId   <= '0;
        end else begin
            if (|w_gnt) begin
                r_opA <= w_selA;
                r_opB <= w_selB;
                r_id  <= w_arbId;
                r_ptr <= (w_arbId == IDW'(NREQ - 1)) ? '0 : w_arbId + 1'b1;
            end
            if (r_state == LO) begin
                r_loSum   <= w_addSum;
                r_loCarry <= w_addCout;
            end
            if (r_state == HI) begin
                r_sum   <= {w_addSum, r_loSum};
                r_cout  <= w_addCout;
                r_outId <= r_id;
            end
        end
    end

    // The grant comes straight from the arbiter. While reset is held the
    // state reads IDLE, so the grant is masked to keep a request from
    // leaking a grant pulse during reset.
    assign o_gnt   = i_rst ? '0 : w_gnt;
    assign o_busy  = w_busy;
    assign o_valid = w_valid;
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_id    = r_outId;

endmodule

// File: tb/tb_cskipa_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cskipa_add_arbiter
//
// Purpose:
//   Directed testbench for cskipa_add_arbiter at WIDTH=31, NREQ=4. Every
//   expected value below is worked out by hand from the operands.
// ---------------------------------------------------------------------------
module tb_cskipa_add_arbiter;

    localparam int W    = 31;
    localparam int NREQ = 4;
    localparam int DW   = 2 * W;

    logic                   i_clk;
    logic                   i_rst;
    logic [NREQ-1:0]        i_req;
    logic [NREQ*DW-1:0]     i_add_term1;
    logic [NREQ*DW-1:0]     i_add_term2;
    logic [NREQ-1:0]        o_gnt;
    logic                   o_busy;
    logic                   o_valid;
    logic [DW-1:0]          o_sum;
    logic                   o_cout;
    logic [1:0]             o_id;

    int vectors;
    int miscompares;

    cskipa_add_arbiter #(
        .WIDTH (W),
        .NREQ  (NREQ)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .o_gnt       (o_gnt),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_id        (o_id)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Load one requester's operands and drive the request vector.
    task automatic applyStimulus(input int slot, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [NREQ-1:0] req);
        i_add_term1[slot*DW +: DW] = a;
        i_add_term2[slot*DW +: DW] = b;
        i_req = req;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Run one isolated operation from IDLE through grant, LO, HI and DONE,
    // plus one more cycle to confirm the result holds. In the cycle after the
    // grant, the slot's term1 is overwritten to show the captured copy is
    // the one that gets used.
    task automatic runOp(input string tag, input int slot, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [NREQ-1:0] expGnt,
                         input logic [DW-1:0] expSum, input logic expCout,
                         input logic [1:0] expId);
        @(negedge i_clk);
        applyStimulus(slot, a, b, NREQ'(1) << slot);
        #1;
        checkOutput($sformatf("%s.gnt", tag), 64'(o_gnt), 64'(expGnt));
        @(negedge i_clk);
        #1;
        i_req = '0;
        i_add_term1[slot*DW +: DW] = ~a;
        checkOutput($sformatf("%s.loBusy", tag), 64'(o_busy), 64'd1);
        checkOutput($sformatf("%s.loGnt", tag), 64'(o_gnt), 64'd0);
        @(negedge i_clk);
        #1;
        checkOutput($sformatf("%s.hiBusy", tag), 64'(o_busy), 64'd1);
        checkOutput($sformatf("%s.hiValid", tag), 64'(o_valid), 64'd0);
        @(negedge i_clk);
        #1;
        checkOutput($sformatf("%s.valid", tag), 64'(o_valid), 64'd1);
        checkOutput($sformatf("%s.sum", tag), 64'(o_sum), 64'(expSum));
        checkOutput($sformatf("%s.cout", tag), 64'(o_cout), 64'(expCout));
        checkOutput($sformatf("%s.id", tag), 64'(o_id), 64'(expId));
        @(negedge i_clk);
        #1;
        checkOutput($sformatf("%s.validDrop", tag), 64'(o_valid), 64'd0);
        checkOutput($sformatf("%s.sumHold", tag), 64'(o_sum), 64'(expSum));
        checkOutput($sformatf("%s.idHold", tag), 64'(o_id), 64'(expId));
    endtask

    // Directed sequence: reset state, arithmetic corner cases with pointer
    // movement, reset during HI, then four-way fairness with requests held.
    initial begin
        logic [NREQ-1:0] expGnt;
        int              expIdx;

        vectors     = 0;
        miscompares = 0;
        i_rst       = 1'b1;
        i_req       = '1;
        i_add_term1 = '0;
        i_add_term2 = '0;

        @(negedge i_clk);
        #1;
        checkOutput("rst.gnt", 64'(o_gnt), 64'd0);
        checkOutput("rst.busy", 64'(o_busy), 64'd0);
        checkOutput("rst.valid", 64'(o_valid), 64'd0);
        checkOutput("rst.sum", 64'(o_sum), 64'd0);
        checkOutput("rst.cout", 64'(o_cout), 64'd0);
        checkOutput("rst.id", 64'(o_id), 64'd0);
        i_req = '0;
        i_rst = 1'b0;

        runOp("carry", 0, 62'h0000_0000_7FFF_FFFF, 62'd1, 4'b0001,
              62'h0000_0000_8000_0000, 1'b0, 2'd0);
        runOp("xhalf", 2, 62'h0000_0000_7FFF_FFFF, 62'd1, 4'b0100,
              62'h0000_0000_8000_0000, 1'b0, 2'd2);
        runOp("ovf", 3, 62'h3FFF_FFFF_FFFF_FFFF, 62'h3FFF_FFFF_FFFF_FFFF, 4'b1000,
              62'h3FFF_FFFF_FFFF_FFFE, 1'b1, 2'd3);
        runOp("wrap", 1, 62'h3FFF_FFFF_FFFF_FFFF, 62'd1, 4'b0010,
              62'h0, 1'b1, 2'd1);
        runOp("alt", 3, 62'h2AAA_AAAA_AAAA_AAAA, 62'h1555_5555_5555_5555, 4'b1000,
              62'h3FFF_FFFF_FFFF_FFFF, 1'b0, 2'd3);

        @(negedge i_clk);
        applyStimulus(2, 62'd5, 62'd6, 4'b0100);
        #1;
        checkOutput("abort.gnt", 64'(o_gnt), 64'b0100);
        @(negedge i_clk);
        #1;
        i_req = '0;
        checkOutput("abort.loBusy", 64'(o_busy), 64'd1);
        @(negedge i_clk);
        #1;
        checkOutput("abort.hiBusy", 64'(o_busy), 64'd1);
        i_rst = 1'b1;
        #1;
        checkOutput("abort.gnt0", 64'(o_gnt), 64'd0);
        checkOutput("abort.busy0", 64'(o_busy), 64'd0);
        checkOutput("abort.valid0", 64'(o_valid), 64'd0);
        checkOutput("abort.sum0", 64'(o_sum), 64'd0);
        checkOutput("abort.cout0", 64'(o_cout), 64'd0);
        checkOutput("abort.id0", 64'(o_id), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkOutput("abort.noValid", 64'(o_valid), 64'd0);
        checkOutput("abort.idleBusy", 64'(o_busy), 64'd0);

        @(negedge i_clk);
        for (int k = 0; k < NREQ; k++) begin
            applyStimulus(k, DW'(k + 1), 62'd100, '1);
        end
        #1;
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) begin
                @(negedge i_clk);
                #1;
            end
            expGnt = ((c % 3) == 0 && c <= 12) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            checkOutput($sformatf("fair.gnt[%0d]", c), 64'(o_gnt), 64'(expGnt));
            checkOutput($sformatf("fair.busy[%0d]", c), 64'(o_busy), 64'((c % 3) != 0));
            checkOutput($sformatf("fair.valid[%0d]", c), 64'(o_valid),
                        64'((c % 3) == 0 && c >= 3));
            if ((c % 3) == 0 && c >= 3) begin
                expIdx = ((c / 3) - 1) % 4;
                checkOutput($sformatf("fair.id[%0d]", c), 64'(o_id), 64'(expIdx));
                checkOutput($sformatf("fair.sum[%0d]", c), 64'(o_sum), 64'(101 + expIdx));
            end
            if (c == 13) begin
                i_req = '0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
